// File: rtl/lsq_fwd_param.sv
`timescale 1ns/1ps
// lsq_fwd_param: in-order load/store queue between the core memory stage and
// the data memory. Requests enqueue in program order and issue in order.
// Completions are tagged by queue ID and may arrive out of order. Retirement
// back to the core is strictly in order. A load whose address matches an
// in-flight store takes that store's data directly and never goes to memory.
// DEPTH must be a power of two (>= 2) with IDW = log2(DEPTH).
module lsq_fwd_param #(
  parameter int DEPTH = 16,
  parameter int IDW   = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CW    = 16,
  parameter int ZW    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           memR,
  input  logic           memW,
  input  logic [AW-1:0]  addr_in_C,
  input  logic [DW-1:0]  data_in_C,
  input  logic [CW-1:0]  cntrl_in_C,
  input  logic [ZW-1:0]  Z_in_C,
  output logic           stall_out_C,
  output logic           empty,
  output logic           ready_out_C,
  output logic [AW-1:0]  addr_out_C,
  output logic [DW-1:0]  data_out_C,
  output logic [CW-1:0]  cntrl_out_C,
  output logic [ZW-1:0]  Z_out_C,
  output logic           rw_out_C,
  output logic [AW-1:0]  addr_out_M,
  output logic [DW-1:0]  data_out_M,
  output logic           rw_out_M,
  output logic [IDW-1:0] ldstID_out_M,
  output logic           valid_out_M,
  input  logic [DW-1:0]  data_in_M,
  input  logic [IDW-1:0] ldstID_in_M,
  input  logic           ready_in_M,
  input  logic           stall_in_M
);

  localparam logic [IDW-1:0] PTR_ONE  = IDW'(1);
  localparam logic [IDW:0]   CNT_ONE  = (IDW+1)'(1);
  localparam logic [IDW:0]   CNT_ZERO = (IDW+1)'(0);
  localparam logic [IDW:0]   CNT_FULL = (IDW+1)'(DEPTH);

  // Per-entry flags and payload
  logic [DEPTH-1:0] busy_q, busy_d, rw_q, rw_d;
  logic [DEPTH-1:0] issued_q, issued_d, done_q, done_d;
  logic [AW-1:0]    addr_q  [DEPTH];
  logic [AW-1:0]    addr_d  [DEPTH];
  logic [DW-1:0]    data_q  [DEPTH];
  logic [DW-1:0]    data_d  [DEPTH];
  logic [CW-1:0]    cntrl_q [DEPTH];
  logic [CW-1:0]    cntrl_d [DEPTH];
  logic [ZW-1:0]    z_q     [DEPTH];
  logic [ZW-1:0]    z_d     [DEPTH];

  // Pointers and occupancy. iss_cnt counts entries the issue pointer has
  // not yet passed, which keeps issue from running past tail when the
  // queue is full and every entry is already issued.
  logic [IDW-1:0] head_q, head_d, issue_q, issue_d, tail_q, tail_d;
  logic [IDW:0]   count_q, count_d, iss_cnt_q, iss_cnt_d;

  // Registered outputs
  logic           ready_c_q, ready_c_d, rw_c_q, rw_c_d;
  logic [AW-1:0]  addr_c_q, addr_c_d;
  logic [DW-1:0]  data_c_q, data_c_d;
  logic [CW-1:0]  cntrl_c_q, cntrl_c_d;
  logic [ZW-1:0]  z_c_q, z_c_d;
  logic           valid_m_q, valid_m_d, rw_m_q, rw_m_d;
  logic [AW-1:0]  addr_m_q, addr_m_d;
  logic [DW-1:0]  data_m_q, data_m_d;
  logic [IDW-1:0] id_m_q, id_m_d;

  // Decoded events for this cycle
  logic           enq_s, issue_go_s, issue_adv_s, ret_go_s, cpl_go_s;
  logic           fwd_hit_s;
  logic [DW-1:0]  fwd_data_s;
  logic [IDW-1:0] fwd_idx_s;

  assign stall_out_C = (count_q == CNT_FULL);
  assign empty       = (count_q == CNT_ZERO);

  // Find the youngest busy store whose address equals the incoming address
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = {DW{1'b0}};
    fwd_idx_s  = head_q;
    // Walk oldest to youngest so the last hit is the youngest match
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx_s = head_q + IDW'(k);
      if (busy_q[fwd_idx_s] && rw_q[fwd_idx_s] && (addr_q[fwd_idx_s] == addr_in_C)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = data_q[fwd_idx_s];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Decode enqueue, issue, completion and retire events from registered state
  always_comb begin
    enq_s      = (memR | memW) & ~stall_out_C;
    issue_go_s = (iss_cnt_q != CNT_ZERO) & ~stall_in_M;
    ret_go_s   = busy_q[head_q] & done_q[head_q];
    cpl_go_s   = ready_in_M & busy_q[ldstID_in_M] & issued_q[ldstID_in_M] & ~done_q[ldstID_in_M];
    // A forwarded load can reach head and retire before the issue pointer
    // has stepped over it (memory stalled); drag issue along so it never
    // points at a freed slot.
    issue_adv_s = issue_go_s | (ret_go_s & (head_q == issue_q) & (iss_cnt_q != CNT_ZERO));
  end

  // Next-state for entries, pointers, counters and registered outputs
  always_comb begin
    busy_d    = busy_q;
    rw_d      = rw_q;
    issued_d  = issued_q;
    done_d    = done_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cntrl_d   = cntrl_q;
    z_d       = z_q;
    ready_c_d = 1'b0;
    rw_c_d    = rw_c_q;
    addr_c_d  = addr_c_q;
    data_c_d  = data_c_q;
    cntrl_c_d = cntrl_c_q;
    z_c_d     = z_c_q;
    valid_m_d = 1'b0;
    rw_m_d    = rw_m_q;
    addr_m_d  = addr_m_q;
    data_m_d  = data_m_q;
    id_m_d    = id_m_q;

    // Enqueue at tail; a forwarded load is born issued and done
    if (enq_s) begin
      busy_d[tail_q]  = 1'b1;
      rw_d[tail_q]    = memW;
      addr_d[tail_q]  = addr_in_C;
      cntrl_d[tail_q] = cntrl_in_C;
      z_d[tail_q]     = Z_in_C;
      if (memW) begin
        data_d[tail_q]   = data_in_C;
        issued_d[tail_q] = 1'b0;
        done_d[tail_q]   = 1'b0;
      end else if (fwd_hit_s) begin
        data_d[tail_q]   = fwd_data_s;
        issued_d[tail_q] = 1'b1;
        done_d[tail_q]   = 1'b1;
      end else begin
        data_d[tail_q]   = {DW{1'b0}};
        issued_d[tail_q] = 1'b0;
        done_d[tail_q]   = 1'b0;
      end
      tail_d = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end

    // In-order issue; already-issued (forwarded) entries are skipped silently
    if (issue_adv_s) begin
      if (issue_go_s && !issued_q[issue_q]) begin
        valid_m_d         = 1'b1;
        addr_m_d          = addr_q[issue_q];
        data_m_d          = data_q[issue_q];
        rw_m_d            = rw_q[issue_q];
        id_m_d            = issue_q;
        issued_d[issue_q] = 1'b1;
      end else begin
        valid_m_d = 1'b0;
      end
      issue_d = issue_q + PTR_ONE;
    end else begin
      issue_d = issue_q;
    end

    // Completion marks the tagged entry done; loads capture the read data
    if (cpl_go_s) begin
      done_d[ldstID_in_M] = 1'b1;
      if (!rw_q[ldstID_in_M]) begin
        data_d[ldstID_in_M] = data_in_M;
      end else begin
        data_d[ldstID_in_M] = data_q[ldstID_in_M];
      end
    end else begin
      done_d = done_d;
    end

    // Retire the head entry once it is done
    if (ret_go_s) begin
      ready_c_d      = 1'b1;
      rw_c_d         = rw_q[head_q];
      addr_c_d       = addr_q[head_q];
      data_c_d       = data_q[head_q];
      cntrl_c_d      = cntrl_q[head_q];
      z_c_d          = z_q[head_q];
      busy_d[head_q] = 1'b0;
      head_d         = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end

    case ({enq_s, ret_go_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case ({enq_s, issue_adv_s})
      2'b10:   iss_cnt_d = iss_cnt_q + CNT_ONE;
      2'b01:   iss_cnt_d = iss_cnt_q - CNT_ONE;
      default: iss_cnt_d = iss_cnt_q;
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= {DEPTH{1'b0}};
      rw_q      <= {DEPTH{1'b0}};
      issued_q  <= {DEPTH{1'b0}};
      done_q    <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= {AW{1'b0}};
        data_q[i]  <= {DW{1'b0}};
        cntrl_q[i] <= {CW{1'b0}};
        z_q[i]     <= {ZW{1'b0}};
      end
      head_q    <= {IDW{1'b0}};
      issue_q   <= {IDW{1'b0}};
      tail_q    <= {IDW{1'b0}};
      count_q   <= CNT_ZERO;
      iss_cnt_q <= CNT_ZERO;
      ready_c_q <= 1'b0;
      rw_c_q    <= 1'b0;
      addr_c_q  <= {AW{1'b0}};
      data_c_q  <= {DW{1'b0}};
      cntrl_c_q <= {CW{1'b0}};
      z_c_q     <= {ZW{1'b0}};
      valid_m_q <= 1'b0;
      rw_m_q    <= 1'b0;
      addr_m_q  <= {AW{1'b0}};
      data_m_q  <= {DW{1'b0}};
      id_m_q    <= {IDW{1'b0}};
    end else begin
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      issued_q  <= issued_d;
      done_q    <= done_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= addr_d[i];
        data_q[i]  <= data_d[i];
        cntrl_q[i] <= cntrl_d[i];
        z_q[i]     <= z_d[i];
      end
      head_q    <= head_d;
      issue_q   <= issue_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      iss_cnt_q <= iss_cnt_d;
      ready_c_q <= ready_c_d;
      rw_c_q    <= rw_c_d;
      addr_c_q  <= addr_c_d;
      data_c_q  <= data_c_d;
      cntrl_c_q <= cntrl_c_d;
      z_c_q     <= z_c_d;
      valid_m_q <= valid_m_d;
      rw_m_q    <= rw_m_d;
      addr_m_q  <= addr_m_d;
      data_m_q  <= data_m_d;
      id_m_q    <= id_m_d;
    end
  end

  assign ready_out_C  = ready_c_q;
  assign rw_out_C     = rw_c_q;
  assign addr_out_C   = addr_c_q;
  assign data_out_C   = data_c_q;
  assign cntrl_out_C  = cntrl_c_q;
  assign Z_out_C      = z_c_q;
  assign valid_out_M  = valid_m_q;
  assign rw_out_M     = rw_m_q;
  assign addr_out_M   = addr_m_q;
  assign data_out_M   = data_m_q;
  assign ldstID_out_M = id_m_q;

endmodule

// File: tb/tb_lsq_fwd_param.sv
`timescale 1ns/1ps
// Scoreboard bench for lsq_fwd_param: stimulus pushes expected retirements
// and expected memory requests; a retire monitor and a memory responder pop
// and compare whenever the DUT presents a transaction.
module tb_lsq_fwd_param;
  localparam int DEPTH = 16, IDW = 4, AW = 32, DW = 32, CW = 16, ZW = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic memR = 1'b0, memW = 1'b0;
  logic [AW-1:0] addr_in_C = '0;
  logic [DW-1:0] data_in_C = '0;
  logic [CW-1:0] cntrl_in_C = '0;
  logic [ZW-1:0] Z_in_C = '0;
  logic stall_out_C, empty, ready_out_C, rw_out_C, rw_out_M, valid_out_M;
  logic [AW-1:0] addr_out_C, addr_out_M;
  logic [DW-1:0] data_out_C, data_out_M;
  logic [CW-1:0] cntrl_out_C;
  logic [ZW-1:0] Z_out_C;
  logic [IDW-1:0] ldstID_out_M;
  logic [DW-1:0] data_in_M = '0;
  logic [IDW-1:0] ldstID_in_M = '0;
  logic ready_in_M = 1'b0, stall_in_M = 1'b0;

  lsq_fwd_param #(.DEPTH(DEPTH), .IDW(IDW), .AW(AW), .DW(DW), .CW(CW), .ZW(ZW)) dut (
    .clk(clk), .rst(rst), .memR(memR), .memW(memW), .addr_in_C(addr_in_C),
    .data_in_C(data_in_C), .cntrl_in_C(cntrl_in_C), .Z_in_C(Z_in_C),
    .stall_out_C(stall_out_C), .empty(empty), .ready_out_C(ready_out_C),
    .addr_out_C(addr_out_C), .data_out_C(data_out_C), .cntrl_out_C(cntrl_out_C),
    .Z_out_C(Z_out_C), .rw_out_C(rw_out_C), .addr_out_M(addr_out_M),
    .data_out_M(data_out_M), .rw_out_M(rw_out_M), .ldstID_out_M(ldstID_out_M),
    .valid_out_M(valid_out_M), .data_in_M(data_in_M), .ldstID_in_M(ldstID_in_M),
    .ready_in_M(ready_in_M), .stall_in_M(stall_in_M));

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr; logic [DW-1:0] data; logic rw; logic [ZW-1:0] z; logic [CW-1:0] cntrl;
  } ret_t;
  typedef struct {
    logic [AW-1:0] addr; logic [DW-1:0] data; logic rw; logic [IDW-1:0] id;
  } req_t;
  typedef struct {
    logic [IDW-1:0] id; logic [DW-1:0] data; int due;
  } pend_t;

  ret_t exp_ret[$];
  req_t exp_req[$];
  pend_t pend[$];
  logic [DW-1:0] exp_mem [logic [AW-1:0]];
  logic [DW-1:0] sim_mem [logic [AW-1:0]];

  int n_vec = 0, n_err = 0;
  int n_ret = 0, n_req = 0, cyc = 0, lat = 2, n_enq = 0;
  logic hold_resp = 1'b0, chk_b2b = 1'b0, saw_wrap = 1'b0;
  int rel_gen = 0, seen_gen = 0;
  logic [IDW-1:0] rel_list[$], rel_q[$];
  logic [IDW-1:0] tb_tail = '0;

  function automatic logic [DW-1:0] mem_def(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Retire monitor: every ready_out_C pulse must match the oldest expectation
  always @(negedge clk) begin
    ret_t e;
    if (!rst && ready_out_C === 1'b1) begin
      n_ret++;
      n_vec++;
      if (exp_ret.size() == 0) begin
        n_err++;
        $display("FAIL retire_unexpected: got addr=%h data=%h, expected no retire", addr_out_C, data_out_C);
      end else begin
        e = exp_ret.pop_front();
        if (addr_out_C !== e.addr || data_out_C !== e.data || rw_out_C !== e.rw ||
            Z_out_C !== e.z || cntrl_out_C !== e.cntrl) begin
          n_err++;
          $display("FAIL retire: got addr=%h data=%h rw=%b z=%h c=%h, expected addr=%h data=%h rw=%b z=%h c=%h",
                   addr_out_C, data_out_C, rw_out_C, Z_out_C, cntrl_out_C,
                   e.addr, e.data, e.rw, e.z, e.cntrl);
        end
      end
    end
  end

  // Memory responder: checks requests, answers after lat cycles or in a forced order
  always @(negedge clk) begin
    req_t r;
    pend_t p;
    logic [IDW-1:0] rid;
    logic found;
    logic [IDW-1:0] prev_id;
    logic have_prev;
    int last_cyc;
    logic have_last;
    cyc++;
    ready_in_M = 1'b0;
    ldstID_in_M = '0;
    data_in_M = '0;
    if (rel_gen != seen_gen) begin
      seen_gen = rel_gen;
      rel_q = rel_list;
    end
    if (rel_q.size() > 0) begin
      rid = rel_q.pop_front();
      found = 1'b0;
      for (int i = 0; i < pend.size(); i++) begin
        if (!found && pend[i].id == rid) begin
          data_in_M = pend[i].data;
          pend.delete(i);
          found = 1'b1;
        end
      end
      if (!found) data_in_M = 32'h0BAD_0000;
      ready_in_M = 1'b1;
      ldstID_in_M = rid;
    end else if (!hold_resp && pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      ready_in_M = 1'b1;
      ldstID_in_M = p.id;
      data_in_M = p.data;
    end
    if (!chk_b2b) have_last = 1'b0;
    if (!rst && valid_out_M === 1'b1) begin
      n_req++;
      n_vec++;
      if (exp_req.size() == 0) begin
        n_err++;
        $display("FAIL request_unexpected: got addr=%h id=%0d rw=%b, expected none", addr_out_M, ldstID_out_M, rw_out_M);
      end else begin
        r = exp_req.pop_front();
        if (addr_out_M !== r.addr || rw_out_M !== r.rw || ldstID_out_M !== r.id ||
            (r.rw && data_out_M !== r.data)) begin
          n_err++;
          $display("FAIL request: got addr=%h id=%0d rw=%b data=%h, expected addr=%h id=%0d rw=%b data=%h",
                   addr_out_M, ldstID_out_M, rw_out_M, data_out_M, r.addr, r.id, r.rw, r.data);
        end
      end
      if (chk_b2b && have_last) begin
        n_vec++;
        if (cyc != last_cyc + 1) begin
          n_err++;
          $display("FAIL issue_b2b: got gap %0d cycles, expected 1", cyc - last_cyc);
        end
      end
      last_cyc = cyc;
      have_last = chk_b2b;
      if (have_prev && prev_id == 4'd15 && ldstID_out_M == 4'd0) saw_wrap = 1'b1;
      prev_id = ldstID_out_M;
      have_prev = 1'b1;
      p.id = ldstID_out_M;
      p.due = cyc + lat;
      if (rw_out_M) begin
        sim_mem[addr_out_M] = data_out_M;
        p.data = 32'h0;
      end else begin
        p.data = sim_mem.exists(addr_out_M) ? sim_mem[addr_out_M] : mem_def(addr_out_M);
      end
      pend.push_back(p);
    end
  end

  // Present one request at a negedge; push its expected request and retirement
  task automatic do_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic fwd);
    int k = 0;
    ret_t e;
    req_t q;
    while (stall_out_C && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) chk("enq_wait_timeout", 64'(k), 64'd0);
    memR = ~rw; memW = rw; addr_in_C = a; data_in_C = d;
    cntrl_in_C = 16'hC000 | 16'(n_enq); Z_in_C = 4'(n_enq);
    e.addr = a; e.rw = rw; e.z = Z_in_C; e.cntrl = cntrl_in_C;
    q.addr = a; q.rw = rw; q.id = tb_tail; q.data = d;
    if (rw) begin
      exp_mem[a] = d;
      e.data = d;
      exp_req.push_back(q);
    end else begin
      e.data = exp_mem.exists(a) ? exp_mem[a] : mem_def(a);
      if (!fwd) exp_req.push_back(q);
    end
    exp_ret.push_back(e);
    tb_tail = tb_tail + 4'd1;
    n_enq++;
    @(negedge clk);
    memR = 1'b0; memW = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_ret.size() != 0 || exp_req.size() != 0) && k < 1000) begin @(negedge clk); k++; end
    chk(name, 64'(k < 1000), 64'd1);
    chk({name, "_empty"}, 64'(empty), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, k;
    logic [IDW-1:0] b;
    exp_mem[32'h40] = 32'hDEADBEEF;
    sim_mem[32'h40] = 32'hDEADBEEF;
    rst = 1'b1;
    #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_stall", 64'(stall_out_C), 64'd0);
    chk("rst_ready", 64'(ready_out_C), 64'd0);
    chk("rst_valid", 64'(valid_out_M), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single load, memory answers after lat cycles
    do_req(1'b0, 32'h40, 32'h0, 1'b0);
    wait_drain("t1_drain");
    chk("t1_data", 64'(data_out_C), 64'hDEADBEEF);
    chk("t1_rw", 64'(rw_out_C), 64'd0);

    // store then forwarded load, then a non-matching load
    r0 = n_req;
    do_req(1'b1, 32'h80, 32'h1234, 1'b0);
    do_req(1'b0, 32'h80, 32'h0, 1'b1);
    do_req(1'b0, 32'h84, 32'h0, 1'b0);
    wait_drain("t2_drain");
    chk("t2_req_count", 64'(n_req - r0), 64'd2);
    chk("t2_last_data", 64'(data_out_C), 64'h00000084 ^ 64'hA5A50000);

    // fill to full with memory stalled, then drop a request while full
    stall_in_M = 1'b1;
    r0 = n_req;
    for (int i = 0; i < 16; i++) do_req(1'b0, 32'h3000 + 32'(4 * i), 32'h0, 1'b0);
    chk("t3_full", 64'(stall_out_C), 64'd1);
    chk("t3_not_empty", 64'(empty), 64'd0);
    memR = 1'b1; addr_in_C = 32'h3FFC;
    @(negedge clk);
    memR = 1'b0;
    chk("t3_still_full", 64'(stall_out_C), 64'd1);
    chk("t3_no_req_stalled", 64'(n_req - r0), 64'd0);
    chk_b2b = 1'b1;
    stall_in_M = 1'b0;
    wait_drain("t3_drain");
    chk_b2b = 1'b0;
    chk("t3_req_count", 64'(n_req - r0), 64'd16);

    // out-of-order completion: answer IDs b+2, b, b+1
    hold_resp = 1'b1;
    b = tb_tail;
    do_req(1'b0, 32'h500, 32'h0, 1'b0);
    do_req(1'b0, 32'h504, 32'h0, 1'b0);
    do_req(1'b0, 32'h508, 32'h0, 1'b0);
    k = 0;
    while (pend.size() < 3 && k < 100) begin @(negedge clk); k++; end
    chk("t4_issued", 64'(pend.size()), 64'd3);
    rel_list = '{b + 4'd2, b, b + 4'd1};
    rel_gen++;
    hold_resp = 1'b0;
    wait_drain("t4_drain");
    chk("t4_last_addr", 64'(addr_out_C), 64'h508);

    // 40 store/load pairs: IDs wrap, loads go to memory
    r0 = n_req;
    for (int i = 0; i < 40; i++) begin
      do_req(1'b1, 32'h1000 + 32'(8 * i), 32'hC0DE0000 + 32'(i), 1'b0);
      do_req(1'b0, 32'h2000 + 32'(8 * i), 32'h0, 1'b0);
    end
    wait_drain("t5_drain");
    chk("t5_req_count", 64'(n_req - r0), 64'd80);
    chk("t5_id_wrap", 64'(saw_wrap), 64'd1);

    // async reset with 5 outstanding loads; late completions must be ignored
    hold_resp = 1'b1;
    for (int i = 0; i < 5; i++) do_req(1'b0, 32'h600 + 32'(4 * i), 32'h0, 1'b0);
    k = 0;
    while (pend.size() < 5 && k < 100) begin @(negedge clk); k++; end
    chk("t6_issued", 64'(pend.size()), 64'd5);
    #2 rst = 1'b1;
    #1;
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_stall", 64'(stall_out_C), 64'd0);
    chk("t6_ready", 64'(ready_out_C), 64'd0);
    chk("t6_valid", 64'(valid_out_M), 64'd0);
    chk("t6_addr_c", 64'(addr_out_C), 64'd0);
    chk("t6_data_c", 64'(data_out_C), 64'd0);
    chk("t6_addr_m", 64'(addr_out_M), 64'd0);
    exp_ret.delete();
    exp_req.delete();
    tb_tail = '0;
    @(negedge clk);
    rst = 1'b0;
    r0 = n_ret;
    rel_list = '{4'd3};
    foreach (pend[i]) rel_list.push_back(pend[i].id);
    rel_gen++;
    repeat (20) @(negedge clk);
    chk("t6_no_retire", 64'(n_ret - r0), 64'd0);
    chk("t6_empty_after", 64'(empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lsq_fwd_param.md
Name: lsq_fwd_param

Overview:
Parametrised successor of the core-side load/store queue. It sits between the core's memory stage and the data memory system. Requests are accepted in program order and issued to memory in order, with issue held off by the memory stall. Memory completions may arrive out of order and are tagged by queue ID. Results retire to the core strictly in order. New relative to the previous generation: configurable depth and widths, a real full/stall output, an issue pointer decoupled from enqueue, and store-to-load forwarding.

Parameters:
DEPTH, 16, queue entries; must be a power of 2, minimum 2
IDW, 4, ID/pointer width; must equal log2(DEPTH)
AW, 32, address width
DW, 32, data width
CW, 16, control bundle width carried through for the core
ZW, 4, destination register tag width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
memR  in  1  core load request
memW  in  1  core store request; wins if memR is also high
addr_in_C  in  AW  request address
data_in_C  in  DW  store data
cntrl_in_C  in  CW  control bundle
Z_in_C  in  ZW  destination tag
stall_out_C  out  1  queue full; core must not present a request
empty  out  1  queue holds no entries
ready_out_C  out  1  one-cycle retire pulse
addr_out_C  out  AW  retired address
data_out_C  out  DW  retired data: load result, or store data
cntrl_out_C  out  CW  retired control bundle
Z_out_C  out  ZW  retired destination tag
rw_out_C  out  1  retired entry was a store
addr_out_M  out  AW  memory request address
data_out_M  out  DW  memory write data
rw_out_M  out  1  1 = write, 0 = read
ldstID_out_M  out  IDW  queue ID of the request
valid_out_M  out  1  request valid this cycle
data_in_M  in  DW  memory read data
ldstID_in_M  in  IDW  ID of the completing request
ready_in_M  in  1  completion valid
stall_in_M  in  1  memory cannot accept a request

Behaviour:
- Reset (async, rst=1): head, issue and tail pointers and count cleared; all entry flags cleared; all outputs 0 except empty=1. Reset asserted mid-operation discards every in-flight entry; completions that arrive later find no outstanding entry and are ignored.
- Per-entry state: busy, rw, issued, done, addr, data, cntrl, Z.
- stall_out_C = (count==DEPTH); empty = (count==0). Both are combinational from count.
- Enqueue: at an edge with (memR|memW) and !stall_out_C, write entry[tail] with busy=1 and rw=memW. tail wraps modulo DEPTH. A request presented while full is dropped.
- Forwarding on load enqueue: search all busy entries older than the tail that have rw=1 and an address equal to addr_in_C. The youngest match wins. On a match, the load is written with data=match.data, done=1, issued=1, and no memory request is made.
- Issue: at each edge, if entry[issue] is busy and !stall_in_M:
  - if it is not yet issued, drive addr/data/rw/ldstID=issue with valid_out_M=1 for one cycle, set issued=1, and advance issue;
  - if it is already issued (forwarded), advance issue with no request.
  - In all other cycles valid_out_M=0. At most one request per cycle.
- Issue latency: an entry enqueued at edge N can show valid_out_M=1 no earlier than after edge N+1.
- Completion: ready_in_M with ldstID_in_M pointing at a busy, issued, not-done entry sets done=1. For loads, data is replaced with data_in_M. Any other completion is ignored.
- Retire: at an edge where entry[head] is busy and done (registered state, sampled before this edge's updates), present its fields, pulse ready_out_C for one cycle, clear busy, and advance head. ready_out_C=0 otherwise; retire data outputs hold their last value.
- A completion for the head entry at edge M produces ready_out_C after edge M+1. A forwarded load at the head enqueued at edge N retires after edge N+1.
- Simultaneous enqueue and retire leave count unchanged. Enqueue into a slot being freed in the same cycle is not allowed, because full is computed before the edge.
- Wrap-around: all pointers are IDW bits and wrap naturally. count is IDW+1 bits.

Test Plan:
- Single load, no forward: LD addr 0x40, memory returns 0xDEADBEEF with ID 0 after 2 cycles -> valid_out_M=1, rw_out_M=0, ldstID_out_M=0; then ready_out_C=1, data_out_C=0xDEADBEEF; empty returns to 1.
- Forwarding: ST addr 0x80 data 0x1234, then LD 0x80 -> exactly one memory request (the store); load retires after the store with data_out_C=0x1234. A load to 0x84 is not forwarded.
- Full: 16 loads with memory stall_in_M=1 -> stall_out_C=1 after the 16th; a 17th request is dropped with count still 16; drop stall_in_M -> IDs 0..15 issue one per cycle.
- Out-of-order completion: 3 loads (IDs 0,1,2) complete in order 2,0,1 -> retire order 0,1,2, each ready_out_C a single-cycle pulse.
- Wrap: 40 store/load pairs with 2-cycle memory -> ldstID_out_M wraps 15->0; all retire data correct; empty=1 at the end.
- Async reset with 5 entries outstanding -> outputs clear immediately without a clock edge, empty=1; late ready_in_M for ID 3 produces no ready_out_C.
